mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one OBI-style memory port (req/gnt address phase, in-order rvalid response phase) between the fetch stage's instruction requester and the memory stage's load/store requester. It selects one requester per address phase and holds that choice until the grant. It tracks up to MAX_OUTSTANDING accepted transactions and routes each response back to its owner. Fetch-side responses made stale by a PC change (branch/trap flush) are discarded.

## Interface
- MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (1..4)
- DATA_STREAK_MAX, 4, consecutive data grants allowed while instr waits before instr is forced
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request; addr held stable until instr_gnt_o
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch address phase accepted
- instr_rvalid_o / instr_rdata_o / instr_err_o  out  1/32/1  fetch response
- instr_flush_i  in  1  PC changed; discard all in-flight fetch responses
- data_req_i  in  1  load/store request; we/be/addr/wdata held until data_gnt_o
- data_we_i / data_be_i / data_addr_i / data_wdata_i  in  1/4/32/32  load/store attributes
- data_gnt_o  out  1  data address phase accepted
- data_rvalid_o / data_rdata_o / data_err_o  out  1/32/1  data response
- mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/4/32/32  memory address phase
- mem_gnt_i  in  1  memory accepts address phase
- mem_rvalid_i / mem_rdata_i / mem_err_i  in  1/32/1  memory response, in order
- protocol_err_o  out  1  sticky: rvalid received with no outstanding transaction

## Operation
- FSM states: IDLE, LOCK_I, LOCK_D.
- IDLE selection: data wins, except when instr_req_i=1 and streak==DATA_STREAK_MAX; then instr wins. Selected requester's attributes drive mem_*. For instr, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- mem_req_o = selected requester's req & ~full. full = (outstanding count == MAX_OUTSTANDING), taken from the registered count. A same-cycle pop does not free a slot.
- Accept = mem_req_o & mem_gnt_i. The owner's gnt = accept; the other gnt = 0.
- IDLE -> LOCK_I/LOCK_D when mem_req_o=1 and mem_gnt_i=0. While locked, the same requester stays selected regardless of priority. LOCK_x -> IDLE on accept.
- LOCK_I -> IDLE also on instr_flush_i. The fetch may then change its address. LOCK_D is never abandoned.
- Streak counter: +1 (saturating) on each data accept while instr_req_i=1. Cleared on instr accept or when instr_req_i=0.
- Outstanding FIFO, depth MAX_OUTSTANDING, entries {owner, discard}. Push on accept with discard=0. Pop on mem_rvalid_i.
- Routing on pop: owner=data -> data_rvalid_o=1. Owner=instr with discard=0 -> instr_rvalid_o=1. Owner=instr with discard=1 -> dropped. rdata/err pass through to both sides unconditionally; only rvalid is gated.
- instr_flush_i sets discard on every occupied instr entry, including an instr entry pushed in the same cycle. An entry popped in the flush cycle is also suppressed.
- mem_rvalid_i with empty FIFO: ignored, protocol_err_o set until reset.

## Timing
- Reset values: state IDLE, count 0, streak 0, FIFO empty, protocol_err_o 0. All gnt/rvalid/mem_req_o are 0 while both reqs are low.
- Request path is combinational: req -> mem_req_o and mem_gnt_i -> *_gnt_o, zero cycles.
- Response path is combinational: mem_rvalid_i -> owner rvalid in the same cycle, no added latency.
- Simultaneous push and pop: count unchanged, ordering preserved.
- Back-to-back accepts allowed every cycle until full.
- Async reset mid-transaction drops all tracking. Responses arriving after reset release raise protocol_err_o.

## Test plan
- Single fetch, addr 0x100, mem_gnt_i same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 with 0xDEADBEEF in cycle 2, data_rvalid_o=0.
- Both reqs high continuously, DATA_STREAK_MAX=4, gnt always 1 -> grant order D,D,D,D,I,D,D,D,D,I…
- Data selected, mem_gnt_i=0 for 3 cycles while instr streak is saturated -> mem_addr_o stays at data addr, state LOCK_D, data_gnt_o only on 4th cycle.
- MAX_OUTSTANDING=2, two accepts without rvalid -> mem_req_o=0 on third request until a registered pop. One rvalid in cycle N -> mem_req_o=1 in cycle N+1.
- Two instr in flight, instr_flush_i for one cycle, then two rvalids -> instr_rvalid_o stays 0. A data request accepted after the flush still returns data_rvalid_o=1.
- mem_rvalid_i=1 with empty FIFO -> no rvalid outputs, protocol_err_o=1 until rstn low.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side OBI signals handled by mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory.
interface mem_port_arbiter_if;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        instr_flush_i;

   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;

   logic        protocol_err_o;

   modport slave (
      input  instr_req_i, instr_addr_i, instr_flush_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      output protocol_err_o
   );

   modport master (
      output instr_req_i, instr_addr_i, instr_flush_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      input  protocol_err_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one OBI memory port between fetch and load/store, tracking outstanding
// transactions in order so each response is routed to its owner (stale fetches dropped).
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic                clk,
   input  logic                rstn,
   mem_port_arbiter_if.slave   bus
);
   localparam int CW = 3;
   localparam int SW = $clog2(DATA_STREAK_MAX + 1);

   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [SW-1:0]              streak_q, streak_d;
   logic [MAX_OUTSTANDING-1:0] own_q, own_d;   // 1 = fetch owns the entry, index 0 is oldest
   logic [MAX_OUTSTANDING-1:0] dis_q, dis_d;
   logic                       perr_q;
   logic                       sel_instr, sel_req, full, accept, pop, streak_sat;

   assign streak_sat = (streak_q == SW'(DATA_STREAK_MAX));
   assign full       = (cnt_q == CW'(MAX_OUTSTANDING));
   assign pop        = bus.mem_rvalid_i && (cnt_q != '0);

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      sel_instr = bus.instr_req_i && (!bus.data_req_i || streak_sat);
      case (state_q)
         LOCK_I:  sel_instr = 1'b1;
         LOCK_D:  sel_instr = 1'b0;
         default: ;
      endcase
   end

   assign sel_req         = sel_instr ? bus.instr_req_i : bus.data_req_i;
   assign bus.mem_req_o   = sel_req && !full;
   assign accept          = bus.mem_req_o && bus.mem_gnt_i;
   assign bus.mem_we_o    = sel_instr ? 1'b0 : bus.data_we_i;
   assign bus.mem_be_o    = sel_instr ? 4'hF : bus.data_be_i;
   assign bus.mem_addr_o  = sel_instr ? bus.instr_addr_i : bus.data_addr_i;
   assign bus.mem_wdata_o = sel_instr ? 32'h0 : bus.data_wdata_i;

   assign bus.instr_gnt_o = accept && sel_instr;
   assign bus.data_gnt_o  = accept && !sel_instr;

   // A response popped in the flush cycle is as stale as the ones still queued.
   assign bus.instr_rvalid_o = pop && own_q[0] && !dis_q[0] && !bus.instr_flush_i;
   assign bus.data_rvalid_o  = pop && !own_q[0];
   assign bus.instr_rdata_o  = bus.mem_rdata_i;
   assign bus.data_rdata_o   = bus.mem_rdata_i;
   assign bus.instr_err_o    = bus.mem_err_i;
   assign bus.data_err_o     = bus.mem_err_i;
   assign bus.protocol_err_o = perr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.mem_req_o && !bus.mem_gnt_i) state_d = sel_instr ? LOCK_I : LOCK_D;
         LOCK_I:  if (accept || bus.instr_flush_i) state_d = IDLE;
         LOCK_D:  if (accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      streak_d = streak_q;
      if (!bus.instr_req_i || (accept && sel_instr)) streak_d = '0;
      else if (accept && !streak_sat)                streak_d = streak_q + 1'b1;
   end

   // Shift-register FIFO: pop shifts toward index 0, push lands just past the survivors.
   always_comb begin
      own_d = own_q;
      dis_d = dis_q;
      cnt_d = cnt_q;
      if (pop) begin
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
            own_d[i] = own_q[i+1];
            dis_d[i] = dis_q[i+1];
         end
         cnt_d = cnt_d - 1'b1;
      end
      if (accept) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (CW'(i) == cnt_d) begin
               own_d[i] = sel_instr;
               dis_d[i] = 1'b0;
            end
         end
         cnt_d = cnt_d + 1'b1;
      end
      if (bus.instr_flush_i) dis_d = dis_d | own_d;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         streak_q <= '0;
         own_q    <= '0;
         dis_q    <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
         own_q    <= own_d;
         dis_q    <= dis_d;
         perr_q   <= perr_q || (bus.mem_rvalid_i && (cnt_q == '0));
      end
   end
endmodule
